// File: rtl/cla_pkg.sv
// Shared constants and result type for the registered 4-bit carry-lookahead adder.
package cla_pkg;

    localparam int CLA_WIDTH = 4;

    // Register bank layout: carry-out, group generate/propagate, then sum bits.
    typedef struct packed {
        logic                 cout;
        logic                 gg;
        logic                 gp;
        logic [CLA_WIDTH-1:0] z;
    } cla_res_t;

    localparam int          RES_BITS    = $bits(cla_res_t);
    localparam logic [RES_BITS-1:0] RESET_VALUE = '0;

endpackage

// File: rtl/cla_if.sv
// Operand/result bundle for the 4-bit adder; bit 0 of each vector is the LSB (x1, y1, z1).
interface cla_if;
    import cla_pkg::*;

    logic [CLA_WIDTH-1:0] x;
    logic [CLA_WIDTH-1:0] y;
    logic                 cin;
    logic [CLA_WIDTH-1:0] z;
    logic                 cout;
    logic                 gg;
    logic                 gp;

    modport master (
        output x, y, cin,
        input  z, cout, gg, gp
    );

    modport slave (
        input  x, y, cin,
        output z, cout, gg, gp
    );

endinterface

// File: rtl/cla4_adder_reg_core.sv
// Combinational 4-bit carry-lookahead: flat generate/propagate sum-of-products, no carry chaining.
module cla4_core
    import cla_pkg::*;
(
    cla_if.slave bus
);

    logic [CLA_WIDTH-1:0] g;
    logic [CLA_WIDTH-1:0] p;
    logic [CLA_WIDTH-1:0] c;

    assign g = bus.x & bus.y;
    assign p = bus.x ^ bus.y;

    // Each carry is expanded directly from g/p/cin so all carries settle in parallel.
    assign c[0] = bus.cin;
    assign c[1] = g[0] | (p[0] & bus.cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bus.cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & bus.cin);

    assign bus.gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0]);
    assign bus.gp = &p;

    assign bus.cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                    | (p[3] & p[2] & p[1] & g[0])
                    | (p[3] & p[2] & p[1] & p[0] & bus.cin);

    assign bus.z = p ^ c;

endmodule

// File: rtl/cla4_adder_reg.sv
// Registered 4-bit carry-lookahead adder with group generate/propagate outputs for cascading.
module cla4_adder_reg
    import cla_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic x1,
    input  logic x2,
    input  logic x3,
    input  logic x4,
    input  logic y1,
    input  logic y2,
    input  logic y3,
    input  logic y4,
    input  logic cin,
    output logic z1,
    output logic z2,
    output logic z3,
    output logic z4,
    output logic cout,
    output logic gg,
    output logic gp
);

    cla_if    bus ();
    cla_res_t res_d;
    cla_res_t res_q;

    assign bus.x   = {x4, x3, x2, x1};
    assign bus.y   = {y4, y3, y2, y1};
    assign bus.cin = cin;

    cla4_core u_core (
        .bus (bus.slave)
    );

    assign res_d.cout = bus.cout;
    assign res_d.gg   = bus.gg;
    assign res_d.gp   = bus.gp;
    assign res_d.z    = bus.z;

    // No input register: the only sequential stage is this 7-bit output bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= cla_res_t'(RESET_VALUE);
        end else begin
            res_q <= res_d;
        end
    end

    assign z1   = res_q.z[0];
    assign z2   = res_q.z[1];
    assign z3   = res_q.z[2];
    assign z4   = res_q.z[3];
    assign cout = res_q.cout;
    assign gg   = res_q.gg;
    assign gp   = res_q.gp;

endmodule

// File: tb/tb_cla4_adder_reg.sv
// Directed and exhaustive checks of the registered 4-bit CLA adder against X+Y+cin.
module tb_cla4_adder_reg;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    cla_if tif ();

    cla4_adder_reg dut (
        .clk   (clk),
        .rst_n (rst_n),
        .x1    (tif.x[0]),
        .x2    (tif.x[1]),
        .x3    (tif.x[2]),
        .x4    (tif.x[3]),
        .y1    (tif.y[0]),
        .y2    (tif.y[1]),
        .y3    (tif.y[2]),
        .y4    (tif.y[3]),
        .cin   (tif.cin),
        .z1    (tif.z[0]),
        .z2    (tif.z[1]),
        .z3    (tif.z[2]),
        .z4    (tif.z[3]),
        .cout  (tif.cout),
        .gg    (tif.gg),
        .gp    (tif.gp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed as {cout, gg, gp, z4, z3, z2, z1}.
    function automatic logic [6:0] model(input logic [3:0] x, input logic [3:0] y, input logic c);
        logic [4:0] s;
        logic [4:0] s0;
        s  = {1'b0, x} + {1'b0, y} + {4'b0000, c};
        s0 = {1'b0, x} + {1'b0, y};
        return {s[4], s0[4], ((x ^ y) == 4'hF), s[3:0]};
    endfunction

    task automatic check(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        obs = {tif.cout, tif.gg, tif.gp, tif.z};
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [3:0] x, input logic [3:0] y, input logic c);
        tif.x   = x;
        tif.y   = y;
        tif.cin = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b1;
        apply(4'b1111, 4'b1111, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("reset_async", 7'b0000000);
        step();
        check("reset_hold_edge", 7'b0000000);

        apply(4'b0000, 4'b0000, 1'b0);
        rst_n = 1'b1;
        step();
        check("zero_operands", 7'b0000000);

        // X=13, Y=11, cin=1 -> 25
        apply(4'b1101, 4'b1011, 1'b1);
        step();
        check("13p11p1", 7'b1101001);

        // All ones, cin=0 -> 30
        apply(4'b1111, 4'b1111, 1'b0);
        step();
        check("15p15", 7'b1101110);

        // All ones, cin=1 -> 31
        apply(4'b1111, 4'b1111, 1'b1);
        step();
        check("15p15p1", 7'b1101111);

        // Full propagate chain: 6+9+1 = 16
        apply(4'b0110, 4'b1001, 1'b1);
        step();
        check("6p9p1_prop", 7'b1010000);

        // Same operands, cin=0: gg/gp unchanged, sum 15
        apply(4'b0110, 4'b1001, 1'b0);
        step();
        check("6p9_cin0", 7'b0011111);

        // 5+11 = 16 via generate
        apply(4'b0101, 4'b1011, 1'b0);
        step();
        check("5p11_gen", 7'b1100000);

        // Outputs hold between edges when inputs move
        apply(4'b0001, 4'b0001, 1'b0);
        #3;
        check("hold_mid_cycle", 7'b1100000);

        // Mid-cycle async reset clears before next edge
        rst_n = 1'b0;
        #1;
        check("reset_mid_cycle", 7'b0000000);
        step();
        check("reset_discard", 7'b0000000);
        rst_n = 1'b1;
        step();
        check("after_reset_1p1", 7'b0000010);

        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            apply(v[3:0], v[7:4], v[8]);
            step();
            check($sformatf("sweep_%0d", i), model(v[3:0], v[7:4], v[8]));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
